// File: rtl/allocator_rr_nx1.sv
// Output-port allocator for a wormhole switch: round-robin arbitration among N_IN inputs,
// with the output locked to the winning input from its head flit until its tail is accepted.
module allocator_rr_nx1 #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned FLIT_W   = 80,
    parameter int unsigned FTYPE_W  = 2,
    parameter int unsigned PORT_W   = 3,
    parameter logic [FTYPE_W-1:0] ENC_HEAD = 2'b00,
    parameter logic [FTYPE_W-1:0] ENC_PAYL = 2'b01,
    parameter logic [FTYPE_W-1:0] ENC_TAIL = 2'b10,
    parameter logic [FTYPE_W-1:0] ENC_SING = 2'b11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORT_W-1:0]        which_port,
    input  logic [N_IN*FLIT_W-1:0]   flit_in,
    input  logic [N_IN-1:0]          valid_in,
    input  logic                     busy_in,
    output logic [N_IN-1:0]          select,
    output logic                     valid_out,
    output logic [N_IN-1:0]          bwd_stall,
    output logic                     shift_ctl,
    output logic                     locked
);

    localparam int unsigned PtrW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0] owner_q, owner_d;
    logic [PtrW-1:0] ptr_q, ptr_d;

    logic [N_IN-1:0] is_head, is_tail, is_sing, request;
    logic [N_IN-1:0] grant, want, sel_int, accept;
    logic [PtrW-1:0] grant_idx;
    logic            grant_any;
    logic            avail;

    // Payload flits need no decode: they reach the output only through the owner lock.
    logic [N_IN-1:0] unused_payl;
    logic            unused_flit_bits;
    assign unused_flit_bits = ^flit_in;

    for (genvar i = 0; i < N_IN; i++) begin : g_dec
        logic [FTYPE_W-1:0] ftype;
        logic [PORT_W-1:0]  port_id;

        assign ftype   = flit_in[i*FLIT_W +: FTYPE_W];
        assign port_id = flit_in[i*FLIT_W+FTYPE_W +: PORT_W];

        assign is_head[i]     = valid_in[i] & (ftype == ENC_HEAD);
        assign unused_payl[i] = valid_in[i] & (ftype == ENC_PAYL);
        assign is_tail[i]     = valid_in[i] & (ftype == ENC_TAIL);
        assign is_sing[i]     = valid_in[i] & (ftype == ENC_SING);
        assign request[i]     = (is_head[i] | is_sing[i]) & (port_id == which_port);
    end

    assign avail = (owner_q == '0) & ~busy_in;

    // First requester found scanning from ptr_q upward with wrap-around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (avail) begin
            for (int unsigned off = 0; off < N_IN; off++) begin
                idx = 32'(ptr_q) + off;
                if (idx >= N_IN) begin
                    idx = idx - N_IN;
                end
                if (!grant_any && request[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = PtrW'(idx);
                    grant_any  = 1'b1;
                end
            end
        end
    end

    assign want    = (request | owner_q) & valid_in;
    assign sel_int = grant | owner_q;
    assign accept  = want & sel_int & ~{N_IN{busy_in}};

    assign select    = grant | (owner_q & valid_in);
    assign valid_out = (|(owner_q & valid_in)) | ((|request) & (owner_q == '0));
    assign bwd_stall = want & (~sel_int | {N_IN{busy_in}});
    assign shift_ctl = grant_any;
    assign locked    = |owner_q;

    // Singles never lock; a tail frees the output only once it has actually been taken.
    assign owner_d = (grant & is_head) | (owner_q & ~(is_tail & accept));

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (32'(grant_idx) + 32'd1 == N_IN) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    a_owner_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(owner_q));
    a_select_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(select));
    a_grant_free : assert property (@(posedge clk) disable iff (rst)
        (grant != '0) |-> (owner_q == '0));

endmodule
